// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: widths, vector-fetch FSM states and pc_sel encodings.
// The pc_sel constants are shared with the control unit.
package fetch_pc_unit_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned SEL_W   = 2;

    localparam logic [STATE_W-1:0] ST_RUN    = 2'b00;
    localparam logic [STATE_W-1:0] ST_VEC_HI = 2'b01;
    localparam logic [STATE_W-1:0] ST_VEC_LO = 2'b10;

    localparam logic [SEL_W-1:0] PCSEL_SEQ = 2'b00;
    localparam logic [SEL_W-1:0] PCSEL_RSV = 2'b01;
    localparam logic [SEL_W-1:0] PCSEL_INT = 2'b10;
    localparam logic [SEL_W-1:0] PCSEL_TGT = 2'b11;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [WORD_W-1:0] word_t;

    // A PC is stored in memory as two words, high word first.
    function automatic pc_t join_words(word_t hi, word_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/memory bundle between the control unit, instruction memory and the fetch PC unit.
// Perf counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_pc_if;
    import fetch_pc_unit_pkg::*;

    logic [SEL_W-1:0] pc_sel;
    logic             fetch_pc_enable;
    pc_t              tgt_addr;
    logic             pop_pc1;
    logic             pop_pc2;
    word_t            mem_rdata;
    word_t            imem_data;
    pc_t              imem_addr;
    pc_t              pc;
    word_t            pc_push_hi;
    word_t            pc_push_lo;
    logic             fetch_valid;
    logic             busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      perf_redirects;
    logic [31:0]      perf_stalls;
`endif

    modport master (
        output pc_sel, fetch_pc_enable, tgt_addr, pop_pc1, pop_pc2, mem_rdata, imem_data,
`ifdef FETCH_PERF_CNT_EN
        input  perf_redirects, perf_stalls,
`endif
        input  imem_addr, pc, pc_push_hi, pc_push_lo, fetch_valid, busy
    );

    modport slave (
        input  pc_sel, fetch_pc_enable, tgt_addr, pop_pc1, pop_pc2, mem_rdata, imem_data,
`ifdef FETCH_PERF_CNT_EN
        output perf_redirects, perf_stalls,
`endif
        output imem_addr, pc, pc_push_hi, pc_push_lo, fetch_valid, busy
    );

endinterface

// File: rtl/fetch_pc_unit_vec_fetch_fsm.sv
// Two-cycle vector fetch sequencer: reads the hi then lo word of the reset/interrupt vector.
module fetch_pc_unit_vec_fetch_fsm
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned RST_VEC_ADDR = 0,
    parameter int unsigned INT_VEC_ADDR = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  int_req,
    input  word_t imem_data,
    output pc_t   vec_addr_c,
    output word_t vec_hi,
    output logic  vec_load_c,
    output logic  run_c,
    output logic  busy_c
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    pc_t                base;
    pc_t                base_nxt;
    word_t              vec_hi_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_VEC_HI;
            base   <= PC_W'(RST_VEC_ADDR);
            vec_hi <= '0;
        end else begin
            state  <= state_nxt;
            base   <= base_nxt;
            vec_hi <= vec_hi_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        base_nxt   = base;
        vec_hi_nxt = vec_hi;
        vec_addr_c = base;
        vec_load_c = 1'b0;
        run_c      = 1'b0;
        busy_c     = 1'b0;
        case (state)
            ST_RUN: begin
                run_c = 1'b1;
                if (int_req) begin
                    base_nxt  = PC_W'(INT_VEC_ADDR);
                    state_nxt = ST_VEC_HI;
                end
            end
            ST_VEC_HI: begin
                busy_c     = 1'b1;
                vec_hi_nxt = imem_data;
                state_nxt  = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                busy_c     = 1'b1;
                vec_addr_c = base + PC_W'(1);
                vec_load_c = 1'b1;
                state_nxt  = ST_RUN;
            end
            default: begin
                // Unused encoding: restart the vector fetch from the current base.
                busy_c    = 1'b1;
                state_nxt = ST_VEC_HI;
            end
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: owns the PC and drives the instruction-memory address.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned RST_VEC_ADDR = 0,
    parameter int unsigned INT_VEC_ADDR = 2
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.slave  bus
);

    pc_t   pc_q;
    pc_t   pc_nxt;
    word_t pop_lo;
    pc_t   vec_addr_c;
    word_t vec_hi;
    logic  vec_load_c;
    logic  run_c;
    logic  busy_c;
    logic  int_req_c;
    logic  redirect_c;

    // Pops outrank every pc_sel redirect, so an interrupt is only taken without a pop.
    assign int_req_c  = run_c && !bus.pop_pc1 && (bus.pc_sel == PCSEL_INT);
    assign redirect_c = run_c && (bus.pop_pc1 || bus.pc_sel == PCSEL_TGT || bus.pc_sel == PCSEL_INT);

    fetch_pc_unit_vec_fetch_fsm #(
        .RST_VEC_ADDR (RST_VEC_ADDR),
        .INT_VEC_ADDR (INT_VEC_ADDR)
    ) u_vec_fsm (
        .clk        (clk),
        .rst        (rst),
        .int_req    (int_req_c),
        .imem_data  (bus.imem_data),
        .vec_addr_c (vec_addr_c),
        .vec_hi     (vec_hi),
        .vec_load_c (vec_load_c),
        .run_c      (run_c),
        .busy_c     (busy_c)
    );

    always_comb begin
        pc_nxt = pc_q;
        if (vec_load_c) begin
            pc_nxt = join_words(vec_hi, bus.imem_data);
        end else if (run_c) begin
            if (bus.pop_pc1)
                pc_nxt = join_words(bus.mem_rdata, pop_lo);
            else if (bus.pc_sel == PCSEL_TGT)
                pc_nxt = bus.tgt_addr;
            else if (bus.pc_sel == PCSEL_INT)
                pc_nxt = pc_q;
            else if (bus.fetch_pc_enable)
                pc_nxt = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            pop_lo <= '0;
        end else begin
            pc_q <= pc_nxt;
            if (bus.pop_pc2)
                pop_lo <= bus.mem_rdata;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = run_c ? pc_q : vec_addr_c;
    assign bus.fetch_valid = run_c;
    assign bus.busy        = busy_c;
    assign bus.pc_push_hi  = pc_q[PC_W-1:WORD_W];
    assign bus.pc_push_lo  = pc_q[WORD_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
    logic        stall_c;

    assign stall_c = run_c && !bus.fetch_pc_enable && !redirect_c;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (redirect_c && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'(1);
            if (stall_c && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'(1);
        end
    end

    assign bus.perf_redirects = perf_redirects;
    assign bus.perf_stalls    = perf_stalls;
`else
    logic unused_redirect;
    assign unused_redirect = redirect_c;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset vector, sequencing, call/return, interrupt, wrap, priority, reset mid-fetch.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_passed;
    word_t imem [16];

    fetch_pc_if bus ();

    fetch_pc_unit #(
        .RST_VEC_ADDR (0),
        .INT_VEC_ADDR (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_data = imem[bus.imem_addr[3:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
        imem[1] = 16'h0100;
        imem[3] = 16'h0300;
        rst                 = 1'b1;
        bus.pc_sel          = PCSEL_SEQ;
        bus.fetch_pc_enable = 1'b0;
        bus.tgt_addr        = '0;
        bus.pop_pc1         = 1'b0;
        bus.pop_pc2         = 1'b0;
        bus.mem_rdata       = '0;
        #1;

        // Reset state and reset-vector fetch
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        chk("rst_valid", 32'(bus.fetch_valid), 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("vec_lo_busy", 32'(bus.busy), 32'h1);
        chk("vec_lo_addr", bus.imem_addr, 32'h1);
        step();
        chk("boot_pc", bus.pc, 32'h0000_0100);
        chk("boot_valid", 32'(bus.fetch_valid), 32'h1);
        chk("boot_busy", 32'(bus.busy), 32'h0);
        chk("boot_imem_addr", bus.imem_addr, 32'h0000_0100);

        // Sequential then freeze
        bus.fetch_pc_enable = 1'b1;
        step(); step(); step();
        chk("seq_pc", bus.pc, 32'h0000_0103);
        bus.fetch_pc_enable = 1'b0;
        step(); step();
        chk("freeze_pc", bus.pc, 32'h0000_0103);
        chk("push_hi", 32'(bus.pc_push_hi), 32'h0000);
        chk("push_lo", 32'(bus.pc_push_lo), 32'h0103);

        // Call overrides freeze, then two-word return
        bus.pc_sel   = PCSEL_TGT;
        bus.tgt_addr = 32'h0000_0200;
        step();
        chk("call_pc", bus.pc, 32'h0000_0200);
        bus.pc_sel    = PCSEL_SEQ;
        bus.pop_pc2   = 1'b1;
        bus.mem_rdata = 16'h0104;
        step();
        chk("pop2_holds_pc", bus.pc, 32'h0000_0200);
        bus.pop_pc2   = 1'b0;
        bus.pop_pc1   = 1'b1;
        bus.mem_rdata = 16'h0000;
        step();
        chk("ret_pc", bus.pc, 32'h0000_0104);
        bus.pop_pc1 = 1'b0;

        // Interrupt vector fetch; pc_sel=11 ignored while busy
        bus.pc_sel          = PCSEL_INT;
        bus.fetch_pc_enable = 1'b1;
        step();
        chk("int_busy", 32'(bus.busy), 32'h1);
        chk("int_valid", 32'(bus.fetch_valid), 32'h0);
        chk("int_hi_addr", bus.imem_addr, 32'h2);
        chk("int_pc_hold", bus.pc, 32'h0000_0104);
        bus.pc_sel   = PCSEL_TGT;
        bus.tgt_addr = 32'h0000_DEAD;
        step();
        chk("int_lo_addr", bus.imem_addr, 32'h3);
        chk("int_lo_pc_hold", bus.pc, 32'h0000_0104);
        step();
        chk("int_pc", bus.pc, 32'h0000_0300);
        chk("int_done_busy", 32'(bus.busy), 32'h0);
        bus.pc_sel          = PCSEL_SEQ;
        bus.fetch_pc_enable = 1'b0;

        // Wrap and priority
        bus.pc_sel   = PCSEL_TGT;
        bus.tgt_addr = 32'hFFFF_FFFF;
        step();
        chk("max_pc", bus.pc, 32'hFFFF_FFFF);
        bus.pc_sel          = PCSEL_SEQ;
        bus.fetch_pc_enable = 1'b1;
        step();
        chk("wrap_pc", bus.pc, 32'h0000_0000);
        bus.fetch_pc_enable = 1'b0;
        bus.pop_pc2         = 1'b1;
        bus.mem_rdata       = 16'h5678;
        step();
        bus.pop_pc2   = 1'b0;
        bus.pop_pc1   = 1'b1;
        bus.mem_rdata = 16'h1234;
        bus.pc_sel    = PCSEL_TGT;
        bus.tgt_addr  = 32'h0000_AAAA;
        step();
        chk("pop_beats_tgt", bus.pc, 32'h1234_5678);
        bus.pc_sel    = PCSEL_SEQ;
        bus.pop_pc2   = 1'b1;
        bus.mem_rdata = 16'h9999;
        step();
        chk("pop12_old_lo", bus.pc, 32'h9999_5678);
        bus.pop_pc2   = 1'b0;
        bus.mem_rdata = 16'h0001;
        step();
        chk("pop1_stale_lo", bus.pc, 32'h0001_9999);
        bus.pop_pc1         = 1'b0;
        bus.pc_sel          = PCSEL_RSV;
        bus.fetch_pc_enable = 1'b1;
        step();
        chk("rsv_is_seq", bus.pc, 32'h0001_999A);

        // Reset in the middle of an interrupt vector fetch
        bus.pc_sel = PCSEL_INT;
        step();
        bus.pc_sel = PCSEL_SEQ;
        step();
        chk("mid_lo_addr", bus.imem_addr, 32'h3);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", bus.pc, 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h1);
        chk("mid_rst_addr", bus.imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_redir_rst", bus.perf_redirects, 32'h0);
        chk("perf_stall_rst", bus.perf_stalls, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("reboot_lo_addr", bus.imem_addr, 32'h1);
        step();
        chk("reboot_pc", bus.pc, 32'h0000_0100);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
